// File: rtl/fir_fifo_consumer.sv
`default_nettype none
// ============================================================================
// Module   : fir_fifo_consumer
// Brief    : Serial-MAC FIR stage popping samples from the sample FIFO (read
//            clock domain), with a valid/ready result port.
//            Define FIR_SAT_EN to saturate the output instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module fir_fifo_consumer #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 16,
    parameter int TAP_AW = 4,
    parameter int OWIDTH = 16,
    parameter int SHIFT  = 15
) (
    input  logic              rd_clk,
    input  logic              areset_n,
    input  logic              fifo_empty,
    output logic              fifo_read,
    input  logic [DWIDTH-1:0] fifo_q,
    input  logic              coef_we,
    input  logic [TAP_AW-1:0] coef_addr,
    input  logic [CWIDTH-1:0] coef_data,
    output logic [OWIDTH-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy
);

    localparam int c_PW = DWIDTH + CWIDTH;
    localparam int c_AW = c_PW + TAP_AW;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_MAC  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [TAP_AW-1:0] c_LAST = TAP_AW'(TAPS - 1);
    localparam logic [TAP_AW:0]   c_TAPS = (TAP_AW + 1)'(TAPS);

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic signed [DWIDTH-1:0] r_x    [0:TAPS-1];
    logic signed [CWIDTH-1:0] r_coef [0:TAPS-1];
    logic signed [c_AW-1:0]   r_acc;
    logic [TAP_AW-1:0]        r_k;
    logic [OWIDTH-1:0]        r_y_data;
    logic                     r_y_valid;

    logic signed [c_PW-1:0]   w_prod;
    logic signed [c_AW-1:0]   w_acc_next;
    logic [OWIDTH-1:0]        w_y_next;
    logic                     w_coef_wr;
    logic                     w_last_mac;

    assign w_prod     = r_coef[r_k] * r_x[r_k];
    assign w_acc_next = r_acc + c_AW'(w_prod);
    assign w_coef_wr  = coef_we && (r_state == c_IDLE) && ({1'b0, coef_addr} < c_TAPS);
    assign w_last_mac = (r_state == c_MAC) && (r_k == c_LAST);

`ifdef FIR_SAT_EN
    localparam logic signed [c_AW-1:0] c_OMAX = {{(c_AW - OWIDTH + 1){1'b0}}, {(OWIDTH - 1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_OMIN = ~c_OMAX;

    logic signed [c_AW-1:0] w_shifted;

    always_comb begin
        w_shifted = w_acc_next >>> SHIFT;
        if (w_shifted > c_OMAX) begin
            w_y_next = {1'b0, {(OWIDTH - 1){1'b1}}};
        end else if (w_shifted < c_OMIN) begin
            w_y_next = {1'b1, {(OWIDTH - 1){1'b0}}};
        end else begin
            w_y_next = w_shifted[OWIDTH-1:0];
        end
    end
`else
    // Taking OWIDTH bits starting at SHIFT is the arithmetic shift with wrap.
    always_comb begin
        w_y_next = w_acc_next[SHIFT +: OWIDTH];
    end
`endif

    always_ff @(posedge rd_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (!coef_we && !fifo_empty) w_state_next = c_LOAD;
            c_LOAD: w_state_next = c_MAC;
            c_MAC:  if (r_k == c_LAST) w_state_next = c_DONE;
            c_DONE: if (y_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // A coefficient write in IDLE defers the pop by one cycle.
    always_comb begin
        fifo_read = areset_n && (r_state == c_IDLE) && !coef_we && !fifo_empty;
        busy      = (r_state != c_IDLE);
    end

    always_ff @(posedge rd_clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= '0;
            end
            r_acc     <= '0;
            r_k       <= '0;
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
        end else begin
            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_data;
            end
            case (r_state)
                c_LOAD: begin
                    for (int i = 1; i < TAPS; i++) begin
                        r_x[i] <= r_x[i-1];
                    end
                    r_x[0] <= fifo_q;
                    r_acc  <= '0;
                    r_k    <= '0;
                end
                c_MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    // Result is formed from the final sum so y_valid rises on DONE entry.
                    if (w_last_mac) begin
                        r_y_data  <= w_y_next;
                        r_y_valid <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (y_ready) begin
                        r_y_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_data  = r_y_data;
    assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_fifo_consumer.sv
`default_nettype none
// Testbench for fir_fifo_consumer: FIFO model, output scoreboard and a
// direct-sum FIR reference model.
module tb_fir_fifo_consumer;

    logic        rd_clk = 1'b0;
    logic        areset_n;
    logic        fifo_empty;
    logic        fifo_read;
    logic [15:0] fifo_q = 16'h0;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [15:0] mem [0:1023];
    int          pushed = 0;
    int          popped = 0;
    int          hist_base = 0;
    logic        hold_empty = 1'b0;
    int          coef_m [0:15];
    logic [15:0] exp_v [0:511];
    logic [15:0] rcv   [0:511];
    int          lat_arr [0:511];
    int          exp_cnt = 0;
    int          rcv_cnt = 0;
    int          cyc = 0;
    int          last_pop = 0;
    int          gap_last = 0;
    int          bad_pop = 0;
    logic        pop_s = 1'b0;
    logic        prev_valid = 1'b0;

    fir_fifo_consumer dut (
        .rd_clk     (rd_clk),
        .areset_n   (areset_n),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_q     (fifo_q),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .y_data     (y_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = hold_empty || (pushed == popped);

    // Output = sum over taps of coef[k] * (sample popped k samples ago), scaled.
    function automatic logic [15:0] model_out(input int idx);
        longint acc;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            if (idx - k >= hist_base)
                acc += longint'(coef_m[k]) * longint'($signed(mem[idx-k]));
        end
        acc = acc >>> 15;
`ifdef FIR_SAT_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return acc[15:0];
    endfunction

    always @(posedge rd_clk) begin
        cyc = cyc + 1;
        if (!areset_n) begin
            exp_cnt   = rcv_cnt;
            hist_base = popped;
        end else if (pop_s) begin
            fifo_q          <= mem[popped];
            exp_v[exp_cnt]  = model_out(popped);
            exp_cnt         = exp_cnt + 1;
            popped          <= popped + 1;
        end
    end

    always @(negedge rd_clk) begin
        pop_s = fifo_read && areset_n;
        if (fifo_read && fifo_empty) bad_pop = bad_pop + 1;
        if (fifo_read) begin
            gap_last = cyc - last_pop;
            last_pop = cyc;
        end
        if (y_valid && !prev_valid) lat_arr[rcv_cnt] = cyc - last_pop;
        prev_valid = y_valid;
        if (y_valid && y_ready && areset_n) begin
            rcv[rcv_cnt] = y_data;
            rcv_cnt      = rcv_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        mem[pushed] = v;
        pushed      = pushed + 1;
    endtask

    task automatic write_coef(input int a, input logic [15:0] v);
        coef_we   = 1'b1;
        coef_addr = a[3:0];
        coef_data = v;
        if (!busy) coef_m[a] = int'($signed(v));
        tick;
        coef_we = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (rcv_cnt >= n) ok = 1'b1;
            else tick;
        end
        if (rcv_cnt >= n) ok = 1'b1;
    endtask

    task automatic test_reset;
        areset_n  = 1'b0;
        y_ready   = 1'b0;
        coef_we   = 1'b0;
        coef_addr = 4'h0;
        coef_data = 16'h0;
        for (int k = 0; k < 16; k++) coef_m[k] = 0;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        checks++; if (y_valid !== 1'b0) $display("FAIL reset_y_valid: got %b want 0", y_valid); else passes++;
        checks++; if (fifo_read !== 1'b0) $display("FAIL reset_fifo_read: got %b want 0", fifo_read); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (y_data !== 16'h0) $display("FAIL reset_y_data: got %h want 0000", y_data); else passes++;
        tick;
        areset_n = 1'b1;
        tick;
    endtask

    task automatic test_impulse;
        int base;
        bit ok;
        y_ready = 1'b1;
        for (int k = 0; k < 16; k++) write_coef(k, 16'((k + 1) * 1024));
        base = rcv_cnt;
        push(16'h4000);
        for (int k = 0; k < 15; k++) push(16'h0000);
        wait_out(base + 16, 16 * 19 + 40, ok);
        checks++; if (!ok) $display("FAIL impulse_timeout: got %0d outputs want %0d", rcv_cnt - base, 16); else passes++;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rcv[base+k] !== 16'((k + 1) * 512))
                $display("FAIL impulse_out[%0d]: got %h want %h", k, rcv[base+k], 16'((k + 1) * 512));
            else passes++;
        end
        checks++; if (lat_arr[base] !== 18) $display("FAIL impulse_latency: got %0d want 18", lat_arr[base]); else passes++;
        checks++; if (gap_last !== 19) $display("FAIL impulse_period: got %0d want 19", gap_last); else passes++;
    endtask

    task automatic test_dc_ramp;
        int base;
        bit ok;
        logic [15:0] e;
        for (int k = 0; k < 16; k++) write_coef(k, 16'h4000);
        base = rcv_cnt;
        for (int k = 0; k < 16; k++) push(16'h2000);
        wait_out(base + 16, 16 * 19 + 40, ok);
        checks++; if (!ok) $display("FAIL dc_timeout: got %0d outputs want 16", rcv_cnt - base); else passes++;
        for (int n = 1; n <= 16; n++) begin
`ifdef FIR_SAT_EN
            e = (n * 4096 > 32767) ? 16'h7FFF : 16'(n * 4096);
`else
            e = 16'(n * 4096);
`endif
            checks++;
            if (rcv[base+n-1] !== e) $display("FAIL dc_out[%0d]: got %h want %h", n, rcv[base+n-1], e);
            else passes++;
        end
    endtask

    task automatic test_backpressure;
        int base;
        bit ok;
        logic [15:0] held;
        y_ready = 1'b0;
        base = rcv_cnt;
        for (int k = 0; k < 3; k++) push(16'($urandom));
        for (int i = 0; i < 40 && !y_valid; i++) tick;
        checks++; if (y_valid !== 1'b1) $display("FAIL bp_valid_timeout: got %b want 1", y_valid); else passes++;
        @(negedge rd_clk);
        held = y_data;
        repeat (50) begin
            @(negedge rd_clk);
            checks++;
            if ({y_valid, fifo_read, y_data} !== {1'b1, 1'b0, held})
                $display("FAIL bp_hold: got v=%b rd=%b d=%h want v=1 rd=0 d=%h", y_valid, fifo_read, y_data, held);
            else passes++;
        end
        tick;
        y_ready = 1'b1;
        @(negedge rd_clk);
        checks++; if (fifo_read !== 1'b0) $display("FAIL bp_accept_cycle_read: got %b want 0", fifo_read); else passes++;
        @(negedge rd_clk);
        checks++; if (fifo_read !== 1'b1) $display("FAIL bp_pop_after_accept: got %b want 1", fifo_read); else passes++;
        @(negedge rd_clk);
        checks++; if (fifo_read !== 1'b0) $display("FAIL bp_single_pop: got %b want 0", fifo_read); else passes++;
        wait_out(base + 3, 3 * 19 + 40, ok);
        checks++; if (!ok) $display("FAIL bp_timeout: got %0d outputs want 3", rcv_cnt - base); else passes++;
        for (int i = base; i < rcv_cnt; i++) begin
            checks++;
            if (rcv[i] !== exp_v[i]) $display("FAIL bp_out[%0d]: got %h want %h", i, rcv[i], exp_v[i]);
            else passes++;
        end
    endtask

    task automatic test_empty;
        int base;
        bit ok;
        for (int i = 0; i < 60 && (busy || !fifo_empty); i++) tick;
        hold_empty = 1'b1;
        base = rcv_cnt;
        push(16'($urandom));
        push(16'($urandom));
        repeat (100) begin
            @(negedge rd_clk);
            checks++;
            if ({fifo_read, busy} !== 2'b00) $display("FAIL empty_hold: got rd=%b busy=%b want 0 0", fifo_read, busy);
            else passes++;
        end
        tick;
        hold_empty = 1'b0;
        @(negedge rd_clk);
        checks++; if (fifo_read !== 1'b1) $display("FAIL empty_release_pop: got %b want 1", fifo_read); else passes++;
        wait_out(base + 2, 2 * 19 + 40, ok);
        checks++; if (!ok) $display("FAIL empty_timeout: got %0d outputs want 2", rcv_cnt - base); else passes++;
        for (int i = base; i < rcv_cnt; i++) begin
            checks++;
            if (rcv[i] !== exp_v[i]) $display("FAIL empty_out[%0d]: got %h want %h", i, rcv[i], exp_v[i]);
            else passes++;
        end
    endtask

    task automatic test_coef_write;
        int base;
        bit ok;
        logic [15:0] v;
        base = rcv_cnt;
        push(16'($urandom));
        for (int i = 0; i < 10 && !busy; i++) tick;
        tick;
        tick;
        write_coef(5, 16'($urandom));
        wait_out(base + 1, 60, ok);
        for (int i = 0; i < 10 && busy; i++) tick;
        v = 16'($urandom);
        coef_we   = 1'b1;
        coef_addr = 4'd3;
        coef_data = v;
        push(16'($urandom));
        @(negedge rd_clk);
        checks++; if (fifo_read !== 1'b0) $display("FAIL coef_pop_deferred: got %b want 0", fifo_read); else passes++;
        tick;
        coef_we   = 1'b0;
        coef_m[3] = int'($signed(v));
        @(negedge rd_clk);
        checks++; if (fifo_read !== 1'b1) $display("FAIL coef_pop_next: got %b want 1", fifo_read); else passes++;
        wait_out(base + 2, 60, ok);
        checks++; if (!ok) $display("FAIL coef_timeout: got %0d outputs want 2", rcv_cnt - base); else passes++;
        for (int i = base; i < rcv_cnt; i++) begin
            checks++;
            if (rcv[i] !== exp_v[i]) $display("FAIL coef_out[%0d]: got %h want %h", i, rcv[i], exp_v[i]);
            else passes++;
        end
    endtask

    task automatic test_random;
        int base;
        for (int k = 0; k < 16; k++) write_coef(k, 16'($urandom));
        base = rcv_cnt;
        for (int k = 0; k < 40; k++) push(16'($urandom));
        for (int i = 0; i < 40 * 19 * 4 && rcv_cnt < base + 40; i++) begin
            y_ready = ($urandom_range(0, 3) != 0);
            tick;
        end
        y_ready = 1'b1;
        checks++; if (rcv_cnt - base !== 40) $display("FAIL random_count: got %0d want 40", rcv_cnt - base); else passes++;
        for (int i = base; i < rcv_cnt; i++) begin
            checks++;
            if (rcv[i] !== exp_v[i]) $display("FAIL random_out[%0d]: got %h want %h", i, rcv[i], exp_v[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        push(16'($urandom));
        for (int i = 0; i < 10 && !busy; i++) tick;
        repeat (5) tick;
        #2;
        areset_n = 1'b0;
        @(negedge rd_clk);
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passes++;
        checks++; if (y_valid !== 1'b0) $display("FAIL midreset_y_valid: got %b want 0", y_valid); else passes++;
        checks++; if (fifo_read !== 1'b0) $display("FAIL midreset_fifo_read: got %b want 0", fifo_read); else passes++;
        checks++; if (y_data !== 16'h0) $display("FAIL midreset_y_data: got %h want 0000", y_data); else passes++;
        for (int k = 0; k < 16; k++) coef_m[k] = 0;
        tick;
        areset_n = 1'b1;
        tick;
        base = rcv_cnt;
        push(16'h7FFF);
        wait_out(base + 1, 60, ok);
        checks++; if (!ok) $display("FAIL midreset_timeout: got %0d outputs want 1", rcv_cnt - base); else passes++;
        checks++; if (rcv[base] !== exp_v[base]) $display("FAIL midreset_out: got %h want %h", rcv[base], exp_v[base]); else passes++;
    endtask

    task automatic test_protocol;
        repeat (25) tick;
        checks++; if (bad_pop !== 0) $display("FAIL pop_while_empty: got %0d want 0", bad_pop); else passes++;
        checks++; if (popped !== pushed) $display("FAIL pop_count: got %0d want %0d", popped, pushed); else passes++;
        checks++; if (rcv_cnt !== exp_cnt) $display("FAIL output_count: got %0d want %0d", rcv_cnt, exp_cnt); else passes++;
    endtask

    initial begin
        test_reset;
        test_impulse;
        test_dc_ramp;
        test_backpressure;
        test_empty;
        test_coef_write;
        test_random;
        test_reset_mid;
        test_protocol;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
